// File: rtl/compositor_pkg.sv
// Shared types and defaults for the sprite compositor slice.
package compositor_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [9:0] coord_t;

    localparam logic [23:0] BG_RGB_DEFAULT  = 24'hFFD700;
    localparam logic [23:0] KEY_RGB_DEFAULT = 24'hFF00FF;
    localparam int          PIPE_LATENCY    = 3;

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite channel: frame-latched position/enable, box test against the
// current pixel, and the registered ROM address for that sprite.
module sprite_hit_unit
    import compositor_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int ADDR_W   = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  coord_t            x_in,
    input  coord_t            y_in,
    input  logic              en_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              in_box
);

    localparam int XB = $clog2(SPRITE_W);
    localparam int YB = $clog2(SPRITE_H);

    coord_t      x_sh;
    coord_t      y_sh;
    logic        en_sh;
    logic [10:0] off_x;
    logic [10:0] off_y;
    logic        box;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_sh  <= '0;
            y_sh  <= '0;
            en_sh <= 1'b0;
        end else if (frame_start) begin
            x_sh  <= x_in;
            y_sh  <= y_in;
            en_sh <= en_in;
        end
    end

    // Bit 10 of the 11-bit difference flags a pixel left of/above the sprite,
    // so sprites near 1023 clip instead of wrapping to column 0.
    always_comb begin
        off_x = {1'b0, DrawX} - {1'b0, x_sh};
        off_y = {1'b0, DrawY} - {1'b0, y_sh};
        box   = en_sh
              && !off_x[10] && (off_x < 11'(SPRITE_W))
              && !off_y[10] && (off_y < 11'(SPRITE_H));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            in_box   <= 1'b0;
        end else begin
            rom_addr <= box ? ADDR_W'({off_y[YB-1:0], off_x[XB-1:0]}) : '0;
            in_box   <= box;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined sprite overlay: per-sprite hit units, ROM-latency alignment,
// fixed-priority colour select and per-frame collision flag.
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter int          NUM_SPRITES = 2,
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          ADDR_W      = $clog2(SPRITE_W * SPRITE_H),
    parameter logic [23:0] BG_RGB      = BG_RGB_DEFAULT,
    parameter logic [23:0] KEY_RGB     = KEY_RGB_DEFAULT
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [NUM_SPRITES*10-1:0]     sprite_x,
    input  logic [NUM_SPRITES*10-1:0]     sprite_y,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*24-1:0]     rom_data,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue,
    output logic                          rgb_valid,
    output logic [NUM_SPRITES-1:0]        sprite_hit,
    output logic                          collision
);

    logic [NUM_SPRITES-1:0]    in_box1;
    logic [NUM_SPRITES-1:0]    in_box_d;
    logic [NUM_SPRITES-1:0]    in_box2;
    logic                      valid1;
    logic                      valid_d;
    logic                      valid2;
    logic [NUM_SPRITES*24-1:0] data2;
    logic                      acc;

    logic [NUM_SPRITES-1:0]    opaque;
    logic [NUM_SPRITES-1:0]    hit_next;
    rgb_t                      colour_next;
    logic                      coll_term;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W)
        ) u_hit (
            .Clk         (Clk),
            .Reset       (Reset),
            .frame_start (frame_start),
            .DrawX       (DrawX),
            .DrawY       (DrawY),
            .x_in        (sprite_x[10*g +: 10]),
            .y_in        (sprite_y[10*g +: 10]),
            .en_in       (sprite_en[g]),
            .rom_addr    (rom_addr[ADDR_W*g +: ADDR_W]),
            .in_box      (in_box1[g])
        );
    end

    // The _d stage waits out the ROM's own register so in-box/valid meet
    // their data when it is captured into data2.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid1   <= 1'b0;
            in_box_d <= '0;
            valid_d  <= 1'b0;
            in_box2  <= '0;
            valid2   <= 1'b0;
            data2    <= '0;
        end else begin
            valid1   <= pix_valid;
            in_box_d <= in_box1;
            valid_d  <= valid1;
            in_box2  <= in_box_d;
            valid2   <= valid_d;
            data2    <= rom_data;
        end
    end

    // Walking from the highest index down lets the lowest opaque index win.
    always_comb begin
        opaque      = '0;
        hit_next    = '0;
        colour_next = BG_RGB;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = in_box2[i] && (data2[24*i +: 24] != KEY_RGB);
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                hit_next    = '0;
                hit_next[i] = 1'b1;
                colour_next = data2[24*i +: 24];
            end
        end
        if (!valid2) begin
            hit_next    = '0;
            colour_next = '0;
        end
        coll_term = valid2 && (|(opaque & (opaque - NUM_SPRITES'(1))));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red        <= '0;
            Green      <= '0;
            Blue       <= '0;
            rgb_valid  <= 1'b0;
            sprite_hit <= '0;
            collision  <= 1'b0;
            acc        <= 1'b0;
        end else begin
            Red        <= colour_next.r;
            Green      <= colour_next.g;
            Blue       <= colour_next.b;
            rgb_valid  <= valid2;
            sprite_hit <= hit_next;
            if (frame_start) begin
                collision <= acc;
                acc       <= coll_term;
            end else begin
                acc <= acc | coll_term;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random traffic
// compared against a pixel-level reference model with a latency queue.
module tb_sprite_compositor;
    import compositor_pkg::*;

    typedef struct {
        logic        valid;
        logic [23:0] rgb;
        logic [1:0]  hit;
        logic        term;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [19:0] sprite_x = '0;
    logic [19:0] sprite_y = '0;
    logic [1:0]  sprite_en = '0;
    logic [15:0] rom_addr;
    logic [23:0] rom_q [2];
    logic [47:0] rom_data;
    logic [7:0]  Red, Green, Blue;
    logic        rgb_valid;
    logic [1:0]  sprite_hit;
    logic        collision;

    exp_t exp_q [$];
    int   sx [2];
    int   sy [2];
    bit   sen [2];
    int   key_addr [2];
    bit   m_acc;
    bit   m_coll;
    int   n_pass = 0;
    int   n_total = 0;

    sprite_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_en   (sprite_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .rgb_valid   (rgb_valid),
        .sprite_hit  (sprite_hit),
        .collision   (collision)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents: sprite 0 returns its address, sprite 1 is offset;
    // one address per sprite holds the transparent key.
    function automatic logic [23:0] pattern(input int i, input int a);
        if (a == key_addr[i]) return 24'hFF00FF;
        return 24'(i * 24'h100000 + a);
    endfunction

    always @(posedge Clk) begin
        rom_q[0] <= pattern(0, int'(rom_addr[7:0]));
        rom_q[1] <= pattern(1, int'(rom_addr[15:8]));
    end
    assign rom_data = {rom_q[1], rom_q[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input bit en);
        sprite_x[10*i +: 10] = 10'(x);
        sprite_y[10*i +: 10] = 10'(y);
        sprite_en[i]         = en;
    endtask

    task automatic reset_model();
        exp_t idle;
        idle.valid = 1'b0;
        idle.rgb   = '0;
        idle.hit   = '0;
        idle.term  = 1'b0;
        exp_q.delete();
        repeat (PIPE_LATENCY) exp_q.push_back(idle);
        for (int i = 0; i < 2; i++) begin
            sx[i]  = 0;
            sy[i]  = 0;
            sen[i] = 1'b0;
        end
        m_acc  = 1'b0;
        m_coll = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, {Red, Green, Blue}, 24'h0);
        chk({tag, "_rgb_valid"}, rgb_valid, 1'b0);
        chk({tag, "_hit"}, sprite_hit, 2'b00);
        chk({tag, "_collision"}, collision, 1'b0);
        chk({tag, "_rom_addr"}, rom_addr, 16'h0);
    endtask

    task automatic check_output(input logic [15:0] exp_addr, input exp_t e);
        chk("rom_addr", rom_addr, exp_addr);
        chk("rgb_valid", rgb_valid, e.valid);
        chk("rgb", {Red, Green, Blue}, e.rgb);
        chk("sprite_hit", sprite_hit, e.hit);
        chk("collision", collision, m_coll);
    endtask

    // One pixel per call: predict from the frame-latched positions, clock it,
    // then compare the pixel that left the pipeline on this edge.
    task automatic apply_stimulus(input bit fs, input bit pv, input int dx, input int dy);
        exp_t        e;
        exp_t        out;
        bit          opq [2];
        int          ox, oy, a, nopq;
        bit          inb;
        logic [15:0] exp_addr;
        frame_start = fs;
        pix_valid   = pv;
        DrawX       = 10'(dx);
        DrawY       = 10'(dy);
        e.valid = 1'b0;
        e.rgb   = '0;
        e.hit   = '0;
        e.term  = 1'b0;
        exp_addr = '0;
        nopq     = 0;
        for (int i = 0; i < 2; i++) begin
            ox  = dx - sx[i];
            oy  = dy - sy[i];
            inb = sen[i] && ox >= 0 && ox < 16 && oy >= 0 && oy < 16;
            a   = inb ? oy * 16 + ox : 0;
            exp_addr[8*i +: 8] = 8'(a);
            opq[i] = inb && (pattern(i, a) != 24'hFF00FF);
            if (opq[i]) nopq++;
        end
        if (pv) begin
            e.valid = 1'b1;
            e.rgb   = 24'hFFD700;
            if (opq[1]) begin e.rgb = pattern(1, int'(exp_addr[15:8])); e.hit = 2'b10; end
            if (opq[0]) begin e.rgb = pattern(0, int'(exp_addr[7:0]));  e.hit = 2'b01; end
            e.term = (nopq >= 2);
        end
        @(posedge Clk);
        #1;
        if (fs) begin
            for (int i = 0; i < 2; i++) begin
                sx[i]  = int'(sprite_x[10*i +: 10]);
                sy[i]  = int'(sprite_y[10*i +: 10]);
                sen[i] = sprite_en[i];
            end
        end
        exp_q.push_back(e);
        out = exp_q.pop_front();
        if (fs) begin
            m_coll = m_acc;
            m_acc  = out.term;
        end else begin
            m_acc = m_acc | out.term;
        end
        check_output(exp_addr, out);
    endtask

    initial begin
        key_addr[0] = 5;
        key_addr[1] = 200;

        // Power-on reset
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("por");
        Reset = 1'b0;
        reset_model();

        // Single sprite, address pattern and right edge
        set_sprite(0, 100, 50, 1'b1);
        set_sprite(1, 600, 600, 1'b0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 103, 52);
        apply_stimulus(0, 1, 116, 52);
        repeat (4) apply_stimulus(0, 0, 0, 0);

        // Overlap raises collision only at the next frame_start, then clears
        set_sprite(0, 200, 200, 1'b1);
        set_sprite(1, 200, 200, 1'b1);
        apply_stimulus(1, 0, 0, 0);
        repeat (3) apply_stimulus(0, 1, 205, 205);
        repeat (4) apply_stimulus(0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        chk("collision_set", collision, 1'b1);
        repeat (4) apply_stimulus(0, 1, 10, 10);
        apply_stimulus(1, 0, 0, 0);
        chk("collision_clear", collision, 1'b0);

        // Keyed sprite-0 pixel reveals sprite 1
        set_sprite(0, 300, 300, 1'b1);
        set_sprite(1, 300, 300, 1'b1);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 305, 300);
        repeat (4) apply_stimulus(0, 0, 0, 0);

        // Right-edge clipping, no wraparound
        set_sprite(0, 1020, 100, 1'b1);
        set_sprite(1, 0, 0, 1'b0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 2, 105);
        set_sprite(0, 1015, 100, 1'b1);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 1023, 105);
        repeat (4) apply_stimulus(0, 0, 0, 0);

        // Position change only takes effect after frame_start
        set_sprite(0, 400, 400, 1'b1);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 402, 402);
        set_sprite(0, 500, 400, 1'b1);
        apply_stimulus(0, 1, 402, 402);
        apply_stimulus(1, 1, 402, 402);
        apply_stimulus(0, 1, 402, 402);
        apply_stimulus(0, 1, 502, 402);
        repeat (4) apply_stimulus(0, 0, 0, 0);

        // Random traffic with occasional frame boundaries
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 2; i++) begin
                set_sprite(i, 100 + int'($urandom_range(0, 30)), 100 + int'($urandom_range(0, 30)),
                           1'($urandom_range(0, 3) != 0));
            end
            apply_stimulus(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 4) != 0),
                           95 + int'($urandom_range(0, 55)), 95 + int'($urandom_range(0, 55)));
        end

        // Reset mid-line with valid pixels in flight
        set_sprite(0, 120, 120, 1'b1);
        apply_stimulus(1, 1, 121, 121);
        apply_stimulus(0, 1, 122, 121);
        apply_stimulus(0, 1, 123, 121);
        Reset = 1'b1;
        #1;
        check_reset_outputs("midline");
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        reset_model();
        set_sprite(0, 120, 120, 1'b1);
        set_sprite(1, 124, 120, 1'b1);
        apply_stimulus(1, 1, 125, 121);
        for (int t = 0; t < 12; t++) begin
            apply_stimulus(0, 1, 118 + t, 121);
        end
        repeat (4) apply_stimulus(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
